// File: rtl/sipo_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_pkg
//  Purpose  : Shared types and line-level constants for the sipo_rx receiver.
//             Provides the receiver state enumeration and the logic levels
//             of the idle line, start bit and stop bit.
//  Revision : 1.0  initial release
// ============================================================================
package sipo_pkg;

    // PARITY is only reachable when the receiver is built with
    // SIPO_RX_PARITY_EN; the encoding is kept identical in both builds.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_rx_if
//  Purpose  : Bundle of the serial-line inputs and parallel-word outputs of
//             the sipo_rx receiver.
//  Ports    : SIN, BIT_EN          - serial line and bit strobe (to receiver)
//             Q, VALID,            - received word and status pulses
//             FRAME_ERR, PAR_ERR     (from receiver)
//  Modports : master - link side (drives the line, consumes the word)
//             slave  - receiver side
//  Revision : 1.0  initial release
// ============================================================================
interface sipo_rx_if #(
    parameter int N = 8
);
    logic         SIN;
    logic         BIT_EN;
    logic [N-1:0] Q;
    logic         VALID;
    logic         FRAME_ERR;
    logic         PAR_ERR;

    modport master (
        output SIN,
        output BIT_EN,
        input  Q,
        input  VALID,
        input  FRAME_ERR,
        input  PAR_ERR
    );

    modport slave (
        input  SIN,
        input  BIT_EN,
        output Q,
        output VALID,
        output FRAME_ERR,
        output PAR_ERR
    );
endinterface : sipo_rx_if
`default_nettype wire

// File: rtl/sipo_shift.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_shift
//  Purpose  : N-bit right-shift register. Each enabled cycle the new bit
//             enters at the MSB, so after N shifts of an LSB-first stream
//             the word is aligned with bit 0 in position 0.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low clear
//             shift_en_i - shift enable
//             din_i      - serial bit entering at the MSB
//             q_o        - register contents
//  Revision : 1.0  initial release
// ============================================================================
module sipo_shift #(
    parameter int N = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         shift_en_i,
    input  wire logic         din_i,
    output logic      [N-1:0] q_o
);

    logic [N-1:0] shreg_q;
    logic [N-1:0] shreg_d;

    generate
        if (N == 1) begin : g_single
            assign shreg_d = din_i;
        end else begin : g_multi
            assign shreg_d = {din_i, shreg_q[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (shift_en_i) begin
            shreg_q <= shreg_d;
        end
    end

    assign q_o = shreg_q;

endmodule : sipo_shift
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_rx
//  Purpose  : Serial-in, parallel-out framed receiver. Samples SIN on BIT_EN
//             strobes, detects the start bit, shifts in N data bits LSB
//             first, optionally checks an even-parity bit, checks the stop
//             bit and presents the word on Q with a one-cycle VALID pulse.
//  Ports    : CLK    - system clock, rising edge
//             n_res  - asynchronous active-low reset
//             bus    - sipo_rx_if.slave (SIN, BIT_EN in; Q, VALID,
//                      FRAME_ERR, PAR_ERR out)
//  Config   : SIPO_RX_PARITY_EN - when defined, one even-parity bit follows
//             the data; a mismatch suppresses the Q update and pulses
//             PAR_ERR. Otherwise PAR_ERR is constant 0.
//  Revision : 1.0  initial release
// ============================================================================
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic CLK,
    input  wire logic n_res,
    sipo_rx_if.slave  bus
);

    localparam int CNT_W = $clog2(N + 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N-1:0]       word_q;
    logic               valid_q;
    logic               ferr_q;
    logic [N-1:0]       shreg_w;
    logic               shift_en_d;
    logic               last_bit_d;

`ifdef SIPO_RX_PARITY_EN
    logic               par_acc_q;   // running XOR of received data bits
    logic               par_bad_q;   // parity bit disagreed with par_acc_q
    logic               perr_q;
`endif

    // The shift register only moves on strobed samples taken in DATA.
    assign shift_en_d = bus.BIT_EN && (state_q == DATA);
    assign last_bit_d = (cnt_q == CNT_W'(N - 1));

    sipo_shift #(
        .N (N)
    ) u_shift (
        .clk        (CLK),
        .rst_n      (n_res),
        .shift_en_i (shift_en_d),
        .din_i      (bus.SIN),
        .q_o        (shreg_w)
    );

    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            par_acc_q <= 1'b0;
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            // Status outputs are single-cycle pulses.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            if (bus.BIT_EN) begin
                case (state_q)
                    IDLE: begin
                        if (bus.SIN == START_BIT) begin
                            state_q   <= DATA;
                            cnt_q     <= '0;
`ifdef SIPO_RX_PARITY_EN
                            par_acc_q <= 1'b0;
`endif
                        end
                    end
                    DATA: begin
                        cnt_q <= cnt_q + CNT_W'(1);
`ifdef SIPO_RX_PARITY_EN
                        par_acc_q <= par_acc_q ^ bus.SIN;
                        if (last_bit_d) begin
                            state_q <= PARITY;
                        end
`else
                        if (last_bit_d) begin
                            state_q <= STOP;
                        end
`endif
                    end
`ifdef SIPO_RX_PARITY_EN
                    PARITY: begin
                        // Even parity: the parity bit equals the XOR of the data.
                        par_bad_q <= (bus.SIN != par_acc_q);
                        state_q   <= STOP;
                    end
`endif
                    STOP: begin
                        // This sample is never treated as a start bit.
                        state_q <= IDLE;
                        if (bus.SIN == STOP_BIT) begin
`ifdef SIPO_RX_PARITY_EN
                            if (par_bad_q) begin
                                perr_q <= 1'b1;
                            end else begin
                                word_q  <= shreg_w;
                                valid_q <= 1'b1;
                            end
`else
                            word_q  <= shreg_w;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.Q         = word_q;
    assign bus.VALID     = valid_q;
    assign bus.FRAME_ERR = ferr_q;
`ifdef SIPO_RX_PARITY_EN
    assign bus.PAR_ERR   = perr_q;
`else
    assign bus.PAR_ERR   = 1'b0;
`endif

endmodule : sipo_rx
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_rx
//  Purpose  : Self-checking bench for sipo_rx (N = 8). Frames are built from
//             their word, parity choice and stop level; the expected outputs
//             at the stop-bit strobe follow directly from those choices and
//             are compared against the DUT every cycle.
//  Config   : SIPO_RX_PARITY_EN - must match the RTL build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sipo_rx;
    import sipo_pkg::*;

    localparam int N = 8;

    logic CLK   = 1'b0;
    logic n_res = 1'b1;

    sipo_rx_if #(.N(N)) bus ();

    sipo_rx #(.N(N)) dut (
        .CLK   (CLK),
        .n_res (n_res),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference expectations for the current cycle.
    logic [N-1:0] exp_q = '0;
    logic         exp_v = 1'b0;
    logic         exp_f = 1'b0;
    logic         exp_p = 1'b0;
    bit           chk_en = 1'b0;
    bit           tog    = 1'b0;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (chk_en) begin
                check1("cyc_Q",         bus.Q,         exp_q);
                check1("cyc_VALID",     bus.VALID,     exp_v);
                check1("cyc_FRAME_ERR", bus.FRAME_ERR, exp_f);
                check1("cyc_PAR_ERR",   bus.PAR_ERR,   exp_p);
            end
        end
    end

    // Drive one cycle and state what the outputs must be after its edge.
    task automatic tick(input logic s, input logic en, input logic v, input logic f,
                        input logic p, input logic [N-1:0] d);
        @(negedge CLK);
        bus.SIN    = s;
        bus.BIT_EN = en;
        @(posedge CLK);
        exp_v = v;
        exp_f = f;
        exp_p = p;
        if (v) exp_q = d;
    endtask

    function automatic logic filler(input bit toggle);
        if (toggle) begin
            tog = ~tog;
            return tog;
        end
        return logic'($urandom_range(1, 0));
    endfunction

    // Unstrobed padding cycles followed by one strobed sample of bit b.
    task automatic strobe_bit(input logic b, input int period, input bit toggle);
        for (int k = 0; k < period - 1; k++) tick(filler(toggle), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(b, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input logic [N-1:0] d, input bit par_ok, input bit stop,
                              input int period, input bit toggle);
        logic v, f, p;
        strobe_bit(START_BIT, period, toggle);
        for (int i = 0; i < N; i++) strobe_bit(d[i], period, toggle);
`ifdef SIPO_RX_PARITY_EN
        strobe_bit((^d) ^ !par_ok, period, toggle);
        p = stop && !par_ok;
`else
        p = 1'b0;
`endif
        f = !stop;
        v = stop && !p;
        for (int k = 0; k < period - 1; k++) tick(filler(toggle), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(stop, 1'b1, v, f, p, d);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        n_res = 1'b0;
        exp_q = '0;
        exp_v = 1'b0;
        exp_f = 1'b0;
        exp_p = 1'b0;
        #1;
        check1("rst_Q",         bus.Q,         0);
        check1("rst_VALID",     bus.VALID,     0);
        check1("rst_FRAME_ERR", bus.FRAME_ERR, 0);
        check1("rst_PAR_ERR",   bus.PAR_ERR,   0);
        @(negedge CLK);
        bus.SIN    = LINE_IDLE;
        bus.BIT_EN = 1'b1;
        @(negedge CLK);
        n_res = 1'b1;
    endtask

    initial begin
        bus.SIN    = LINE_IDLE;
        bus.BIT_EN = 1'b0;
        #3;
        do_reset();
        chk_en = 1'b1;

        // Idle line keeps the receiver quiet.
        for (int k = 0; k < 3; k++) tick(LINE_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Good frame 0xA5.
        send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0);
        #1;
        check1("a5_VALID", bus.VALID, 1);
        check1("a5_Q",     bus.Q,     8'hA5);
        tick(LINE_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        check1("a5_VALID_drop", bus.VALID, 0);

        // Framing error keeps the previous word.
        send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b0);
        #1;
        check1("ferr_FRAME_ERR", bus.FRAME_ERR, 1);
        check1("ferr_VALID",     bus.VALID,     0);
        check1("ferr_Q",         bus.Q,         8'hA5);

`ifdef SIPO_RX_PARITY_EN
        send_frame(8'h01, 1'b0, 1'b1, 1, 1'b0);
        #1;
        check1("perr_PAR_ERR", bus.PAR_ERR, 1);
        check1("perr_Q",       bus.Q,       8'hA5);
        send_frame(8'h01, 1'b1, 1'b1, 1, 1'b0);
        #1;
        check1("pok_VALID", bus.VALID, 1);
        check1("pok_Q",     bus.Q,     8'h01);
`endif

        // Strobe every 4th cycle, line toggling in between.
        send_frame(8'hFF, 1'b1, 1'b1, 4, 1'b1);
        #1;
        check1("gate_VALID", bus.VALID, 1);
        check1("gate_Q",     bus.Q,     8'hFF);

        // Reset after four data bits discards the partial word.
        strobe_bit(START_BIT, 1, 1'b0);
        for (int i = 0; i < 4; i++) strobe_bit(logic'(i[0]), 1, 1'b0);
        do_reset();

        // Back-to-back frames with no idle gap.
        send_frame(8'h12, 1'b1, 1'b1, 1, 1'b0);
        #1;
        check1("b2b_Q1", bus.Q, 8'h12);
        send_frame(8'h34, 1'b1, 1'b1, 1, 1'b0);
        #1;
        check1("b2b_Q2", bus.Q, 8'h34);

        // Randomized frames, strobe spacing, idle gaps and error injection.
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(2, 0));
            for (int k = 0; k < gap; k++) tick(LINE_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            send_frame(N'($urandom), ($urandom % 6) != 0, ($urandom % 8) != 0,
                       int'($urandom_range(3, 1)), 1'b0);
        end

        for (int k = 0; k < 3; k++) tick(LINE_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sipo_rx
`default_nettype wire
